// File: rtl/neuron_accumulator.sv
// neuron_accumulator: multiply-accumulates (weight, act_in) beats on a bias and rounds the sum to Q_INT.Q_FRAC.
// Optional clipping of out-of-range results is enabled by defining NEURON_ACC_SATURATE_EN.

package definitions;
  parameter int Q_INT         = 8;
  parameter int Q_FRAC        = 8;
  parameter int ACT_MASK_SIZE = 4;
endpackage

module neuron_accumulator #(
  parameter int Q_INT     = definitions::Q_INT,
  parameter int Q_FRAC    = definitions::Q_FRAC,
  parameter int ACC_GUARD = 8,
  parameter int MASK_W    = definitions::ACT_MASK_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic                     in_last,
  input  logic [Q_INT+Q_FRAC-1:0]  weight,
  input  logic [Q_INT+Q_FRAC-1:0]  act_in,
  input  logic [Q_INT+Q_FRAC-1:0]  bias,
  input  logic [MASK_W-1:0]        mask_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [Q_INT+Q_FRAC-1:0]  x_out,
  output logic [MASK_W-1:0]        mask_out,
  output logic                     overflow
);

  localparam int Q_DEPTH  = Q_INT + Q_FRAC;
  localparam int PROD_W   = 2 * Q_DEPTH;
  localparam int ACC_W    = PROD_W + ACC_GUARD;
  localparam int BIAS_EXT = ACC_W - Q_DEPTH - Q_FRAC;
  localparam logic signed [ACC_W-1:0] ROUND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (Q_FRAC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_ROUND  = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [ACC_W-1:0]   acc_next_s;
  logic [MASK_W-1:0]         mask_r;
  logic [MASK_W-1:0]         mask_next_s;
  logic [Q_DEPTH-1:0]        x_out_r;
  logic [MASK_W-1:0]         mask_out_r;
  logic                      overflow_r;
  logic                      out_valid_r;
  logic                      in_ready_r;

  logic                      beat_s;
  logic                      load_result_s;
  logic                      release_s;
  logic                      in_ready_next_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [ACC_W-1:0]   prod_ext_s;
  logic signed [ACC_W-1:0]   bias_ext_s;
  logic signed [ACC_W-1:0]   acc_rnd_s;
  logic [Q_DEPTH-1:0]        result_s;
  logic                      result_ovf_s;

  assign beat_s     = in_valid & in_ready_r;
  assign prod_s     = $signed(weight) * $signed(act_in);
  assign prod_ext_s = {{ACC_GUARD{prod_s[PROD_W-1]}}, prod_s};
  // Bias is aligned to the product's 2*Q_FRAC fractional bits.
  assign bias_ext_s = {{BIAS_EXT{bias[Q_DEPTH-1]}}, bias, {Q_FRAC{1'b0}}};
  assign acc_rnd_s  = acc_r + ROUND_HALF;

`ifdef NEURON_ACC_SATURATE_EN
  localparam int HI_W = ACC_W - Q_DEPTH + 1;

  function automatic logic [Q_DEPTH:0] saturate(input logic signed [ACC_W-1:0] r);
    logic [HI_W-1:0]  hi;
    logic [Q_DEPTH:0] res;
    hi = r[ACC_W-1:Q_DEPTH-1];
    if ((hi == {HI_W{1'b0}}) || (hi == {HI_W{1'b1}})) begin
      res = {1'b0, r[Q_DEPTH-1:0]};
    end else if (r[ACC_W-1]) begin
      res = {1'b1, 1'b1, {(Q_DEPTH-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(Q_DEPTH-1){1'b1}}};
    end
    return res;
  endfunction

  logic signed [ACC_W-1:0] rounded_s;
  assign rounded_s = acc_rnd_s >>> Q_FRAC;
  assign {result_ovf_s, result_s} = saturate(rounded_s);
`else
  assign result_s     = Q_DEPTH'(acc_rnd_s >>> Q_FRAC);
  assign result_ovf_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; a first beat restarts the neuron from IDLE or ACCUM
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (beat_s && in_first) begin
          state_next_s = in_last ? ST_ROUND : ST_ACCUM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (beat_s && in_last) begin
          state_next_s = ST_ROUND;
        end else begin
          state_next_s = ST_ACCUM;
        end
      end
      ST_ROUND: begin
        state_next_s = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_OUTPUT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Control outputs of the FSM
  always_comb begin
    load_result_s   = 1'b0;
    release_s       = 1'b0;
    in_ready_next_s = 1'b0;
    case (state_r)
      ST_ROUND:  load_result_s = 1'b1;
      ST_OUTPUT: release_s     = out_ready;
      default:   load_result_s = 1'b0;
    endcase
    case (state_next_s)
      ST_IDLE, ST_ACCUM: in_ready_next_s = 1'b1;
      default:           in_ready_next_s = 1'b0;
    endcase
  end

  // Accumulator and mask next values; non-first beats in IDLE are dropped
  always_comb begin
    acc_next_s  = acc_r;
    mask_next_s = mask_r;
    if (beat_s && in_first) begin
      acc_next_s  = bias_ext_s + prod_ext_s;
      mask_next_s = mask_in;
    end else if (beat_s && (state_r == ST_ACCUM)) begin
      acc_next_s  = acc_r + prod_ext_s;
      mask_next_s = mask_r;
    end else begin
      acc_next_s  = acc_r;
      mask_next_s = mask_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r  <= {ACC_W{1'b0}};
      mask_r <= {MASK_W{1'b0}};
    end else begin
      acc_r  <= acc_next_s;
      mask_r <= mask_next_s;
    end
  end

  // Output registers; result is captured once in ROUND and held through OUTPUT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out_r     <= {Q_DEPTH{1'b0}};
      mask_out_r  <= {MASK_W{1'b0}};
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      in_ready_r <= in_ready_next_s;
      if (load_result_s) begin
        x_out_r     <= result_s;
        mask_out_r  <= mask_r;
        overflow_r  <= result_ovf_s;
        out_valid_r <= 1'b1;
      end else if (release_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = x_out_r;
  assign mask_out  = mask_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator (Q8.8, 4-bit mask) using an output scoreboard.
module tb_neuron_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [15:0] weight;
  logic [15:0] act_in;
  logic [15:0] bias;
  logic [3:0]  mask_in;
  logic        out_ready;
  logic        in_ready;
  logic        out_valid;
  logic        overflow;
  logic [15:0] x_out;
  logic [3:0]  mask_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [15:0] x;
    logic [3:0]  m;
    logic        o;
  } exp_t;

  exp_t sb[$];

  neuron_accumulator #(
    .Q_INT(8), .Q_FRAC(8), .ACC_GUARD(8), .MASK_W(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .weight(weight), .act_in(act_in),
    .bias(bias), .mask_in(mask_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .mask_out(mask_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Scoreboard: every output transfer is compared against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got x_out=%h with no expected result", x_out);
      end else begin
        e = sb.pop_front();
        if ({x_out, mask_out, overflow} !== {e.x, e.m, e.o}) begin
          n_fail++;
          $display("FAIL sb_result: got x=%h m=%h ovf=%b required x=%h m=%h ovf=%b",
                   x_out, mask_out, overflow, e.x, e.m, e.o);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input logic [15:0] w, input logic [15:0] a,
                      input logic [15:0] b, input logic [3:0] m);
    int guard = 0;
    in_valid = 1'b1; in_first = f; in_last = l;
    weight = w; act_in = a; bias = b; mask_in = m;
    while (in_ready !== 1'b1 && guard < 50) begin
      tick;
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: got in_ready=%b required 1", in_ready);
    end
    tick;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    tick;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending results required 0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    weight = 16'h0000; act_in = 16'h0000; bias = 16'h0000; mask_in = 4'h0;
    repeat (3) tick;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready);
    end
    n_checks++;
    if ({out_valid, overflow, x_out, mask_out} !== {1'b0, 1'b0, 16'h0000, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b o=%b x=%h m=%h required all 0",
               out_valid, overflow, x_out, mask_out);
    end
    reset = 1'b0;
    tick;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    sb.push_back('{x: 16'h0940, m: 4'h5, o: 1'b0});
    beat(1'b1, 1'b0, 16'h0180, 16'h0200, 16'h0040, 4'h5);
    beat(1'b0, 1'b0, 16'h0180, 16'h0200, 16'h0000, 4'h0);
    beat(1'b0, 1'b1, 16'h0180, 16'h0200, 16'h0000, 4'h0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_e0: got v=%b rdy=%b required v=0 rdy=0", out_valid, in_ready);
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_latency: got out_valid=%b required 1", out_valid);
    end
    tick;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL basic_e2: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    wait_drain("basic");
  endtask

  task automatic test_rounding;
    out_ready = 1'b1;
    sb.push_back('{x: 16'h0001, m: 4'h1, o: 1'b0});
    beat(1'b1, 1'b1, 16'h0001, 16'h0080, 16'h0000, 4'h1);
    sb.push_back('{x: 16'h0000, m: 4'h2, o: 1'b0});
    beat(1'b1, 1'b1, 16'hFFFF, 16'h0080, 16'h0000, 4'h2);
    sb.push_back('{x: 16'h0000, m: 4'h3, o: 1'b0});
    beat(1'b1, 1'b1, 16'h0001, 16'h007F, 16'h0000, 4'h3);
    sb.push_back('{x: 16'hFFFF, m: 4'h4, o: 1'b0});
    beat(1'b1, 1'b1, 16'hFFFF, 16'h0081, 16'h0000, 4'h4);
    wait_drain("rounding");
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
`ifdef NEURON_ACC_SATURATE_EN
    sb.push_back('{x: 16'h7FFF, m: 4'h7, o: 1'b1});
`else
    sb.push_back('{x: 16'hA000, m: 4'h7, o: 1'b0});
`endif
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 16'h0400, 16'h0400, 16'h0000, 4'h7);
`ifdef NEURON_ACC_SATURATE_EN
    sb.push_back('{x: 16'h8000, m: 4'h8, o: 1'b1});
`else
    sb.push_back('{x: 16'h6000, m: 4'h8, o: 1'b0});
`endif
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 16'h0400, 16'hFC00, 16'h0000, 4'h8);
    wait_drain("saturation");
  endtask

  task automatic test_backpressure;
    int guard = 0;
    out_ready = 1'b0;
    sb.push_back('{x: 16'h0310, m: 4'hA, o: 1'b0});
    beat(1'b1, 1'b1, 16'h0100, 16'h0300, 16'h0010, 4'hA);
    while (out_valid !== 1'b1 && guard < 10) begin
      tick;
      guard++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_valid_timeout: got out_valid=%b required 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++;
      if ({out_valid, in_ready, x_out, mask_out} !== {1'b1, 1'b0, 16'h0310, 4'hA}) begin
        n_fail++;
        $display("FAIL bp_hold: got v=%b rdy=%b x=%h m=%h required v=1 rdy=0 x=0310 m=a",
                 out_valid, in_ready, x_out, mask_out);
      end
    end
    out_ready = 1'b1;
    tick;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got v=%b rdy=%b required v=0 rdy=1", out_valid, in_ready);
    end
    wait_drain("backpressure");
  endtask

  task automatic test_restart;
    out_ready = 1'b1;
    sb.push_back('{x: 16'h0200, m: 4'hC, o: 1'b0});
    beat(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 4'h3);
    beat(1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 4'h3);
    beat(1'b1, 1'b0, 16'h0200, 16'h0080, 16'h0000, 4'hC);
    beat(1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 4'h0);
    wait_drain("restart");
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    out_ready = 1'b1;
    beat(1'b1, 1'b0, 16'h0100, 16'h0100, 16'h0100, 4'h9);
    beat(1'b0, 1'b0, 16'h0100, 16'h0100, 16'h0000, 4'h0);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, in_ready, overflow, x_out, mask_out} !== {1'b0, 1'b0, 1'b0, 16'h0000, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b rdy=%b o=%b x=%h m=%h required all 0",
               out_valid, in_ready, overflow, x_out, mask_out);
    end
    tick;
    reset = 1'b0;
    tick;
    beat(1'b0, 1'b1, 16'h0100, 16'h0100, 16'h0000, 4'h6);
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick;
    end
    n_checks++;
    if (seen) begin
      n_fail++; $display("FAIL reset_mid_no_output: got out_valid=1 required 0");
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_idle_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      int          nb;
      longint      sum;
      longint      r;
      logic [15:0] b;
      logic [15:0] w;
      logic signed [15:0] a;
      logic [3:0]  m;
      exp_t        e;
      nb  = $urandom_range(1, 4);
      b   = 16'($urandom);
      m   = 4'($urandom);
      sum = longint'($signed(b)) * 256;
      for (int i = 0; i < nb; i++) begin
        w   = 16'($urandom);
        a   = 16'($urandom);
        a   = a >>> $urandom_range(0, 12);
        sum = sum + longint'($signed(w)) * longint'(a);
        beat(i == 0, i == nb - 1, w, a, b, m);
      end
      r = (sum + 128) >>> 8;
`ifdef NEURON_ACC_SATURATE_EN
      if (r > 32767) e = '{x: 16'h7FFF, m: m, o: 1'b1};
      else if (r < -32768) e = '{x: 16'h8000, m: m, o: 1'b1};
      else e = '{x: r[15:0], m: m, o: 1'b0};
`else
      e = '{x: r[15:0], m: m, o: 1'b0};
`endif
      sb.push_back(e);
    end
    wait_drain("back_to_back");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_saturation;
    test_backpressure;
    test_restart;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
